// File: rtl/apb_timer_ctrl_if.sv
// APB3 bus bundle between a master and the apb_timer_ctrl register block.
interface apb_timer_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_timer_ctrl.sv
// APB3 register block feeding the timer enable/final value and collecting its done pulses.
// Optional: define TIMER_CTRL_LOAD_LOCK_EN to reject LOAD writes while the timer is enabled.
module apb_timer_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int WAIT_STATES = 0,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            reset,
  apb_timer_ctrl_if.slave apb,
  output logic            timer_enable,
  output logic [9:0]      final_value,
  input  logic            timer_done,
  output logic            irq
);
  // state  | meaning
  // IDLE   | no transfer; watching for a setup phase
  // SETUP  | setup phase sampled; first access cycle, wait counter loaded
  // ACCESS | later access cycles while the wait counter runs down
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [2:0]        wait_q, wait_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0]        ctrl_q;
  logic [9:0]        load_q;
  logic              sticky_q;
  logic [CNT_W-1:0]  ticks_q;
  logic              irq_q;

  logic              setup_seen, complete, unmapped, lock_err, wr_ok;
  logic [1:0]        reg_sel;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_bits;

  assign reg_sel     = apb.paddr[3:2];
  assign unmapped    = (apb.paddr >> 4) != '0;
  assign setup_seen  = apb.psel & ~apb.penable;
  assign complete    = (state_q != IDLE) & apb.psel & ready_q;
  assign unused_bits = ^{apb.pwdata[DATA_W-1:10], apb.paddr[1:0]};

`ifdef TIMER_CTRL_LOAD_LOCK_EN
  assign lock_err = apb.pwrite & (reg_sel == 2'd1) & ctrl_q[0];
`else
  assign lock_err = 1'b0;
`endif

  assign wr_ok = complete & apb.pwrite & ~unmapped & ~lock_err;

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      2'd0:    rd_mux[1:0]       = ctrl_q;
      2'd1:    rd_mux[9:0]       = load_q;
      2'd2:    rd_mux[0]         = sticky_q;
      default: rd_mux[CNT_W-1:0] = ticks_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (setup_seen) begin
          state_d = SETUP;
          wait_d  = 3'(WAIT_STATES);
        end
      end
      SETUP, ACCESS: begin
        // a completed beat or a dropped psel both return to IDLE, which
        // picks up a back-to-back setup phase on the following cycle
        if (!apb.psel || ready_q) begin
          state_d = IDLE;
        end else begin
          state_d = ACCESS;
          if (wait_q != 3'd0) wait_d = wait_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // pready is registered, so it is decided one cycle ahead of the beat it ends
  always_comb begin
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE:          ready_d = setup_seen && (WAIT_STATES == 0);
      SETUP, ACCESS: ready_d = apb.psel && !ready_q && (wait_q == 3'd1);
      default:       ready_d = 1'b0;
    endcase
    if (ready_d) begin
      err_d   = unmapped | lock_err;
      rdata_d = (apb.pwrite || unmapped) ? '0 : rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= '0;
      load_q   <= '0;
      sticky_q <= 1'b0;
      ticks_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= sticky_q & ctrl_q[1];
      if (wr_ok && reg_sel == 2'd0) ctrl_q <= apb.pwdata[1:0];
      if (wr_ok && reg_sel == 2'd1) load_q <= apb.pwdata[9:0];
      if (timer_done)
        sticky_q <= 1'b1;
      else if (wr_ok && reg_sel == 2'd2 && apb.pwdata[0])
        sticky_q <= 1'b0;
      if (wr_ok && reg_sel == 2'd3)
        ticks_q <= CNT_W'(timer_done);
      else if (timer_done)
        ticks_q <= ticks_q + CNT_W'(1);
    end
  end

  assign apb.pready   = ready_q;
  assign apb.pslverr  = err_q;
  assign apb.prdata   = rdata_q;
  assign timer_enable = ctrl_q[0];
  assign final_value  = load_q;
  assign irq          = irq_q;
endmodule

// File: tb/tb_apb_timer_ctrl.sv
// Directed bench for apb_timer_ctrl: a zero-wait instance plus a 3-wait-state, 5-bit-address instance.
module tb_apb_timer_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        timer_done, done_ws;
  logic        psel_v, penable_v, pwrite_v, sel_ws;
  logic [4:0]  paddr_v;
  logic [31:0] pwdata_v;
  logic        timer_enable, irq, te_ws, irq_ws;
  logic [9:0]  final_value, fv_ws;
  int          vectors = 0;
  int          errs    = 0;

`ifdef TIMER_CTRL_LOAD_LOCK_EN
  localparam logic LOCK = 1'b1;
`else
  localparam logic LOCK = 1'b0;
`endif

  apb_timer_ctrl_if #(.ADDR_W(4), .DATA_W(32)) bus ();
  apb_timer_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus_ws ();

  assign bus.psel       = psel_v & ~sel_ws;
  assign bus.penable    = penable_v;
  assign bus.pwrite     = pwrite_v;
  assign bus.paddr      = paddr_v[3:0];
  assign bus.pwdata     = pwdata_v;
  assign bus_ws.psel    = psel_v & sel_ws;
  assign bus_ws.penable = penable_v;
  assign bus_ws.pwrite  = pwrite_v;
  assign bus_ws.paddr   = paddr_v;
  assign bus_ws.pwdata  = pwdata_v;

  always #5 clk = ~clk;

  apb_timer_ctrl #(.DATA_W(32), .ADDR_W(4), .WAIT_STATES(0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .apb(bus), .timer_enable(timer_enable),
    .final_value(final_value), .timer_done(timer_done), .irq(irq));

  apb_timer_ctrl #(.DATA_W(32), .ADDR_W(5), .WAIT_STATES(3), .CNT_W(16)) dut_ws (
    .clk(clk), .reset(reset), .apb(bus_ws), .timer_enable(te_ws),
    .final_value(fv_ws), .timer_done(done_ws), .irq(irq_ws));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic ws, input logic wr, input logic [4:0] addr,
                      input logic [31:0] wd, input logic done_hit,
                      output logic [31:0] rd, output logic err, output int waits);
    logic rdy;
    @(posedge clk); #1;
    sel_ws = ws; psel_v = 1'b1; penable_v = 1'b0;
    pwrite_v = wr; paddr_v = addr; pwdata_v = wd;
    @(posedge clk); #1;
    penable_v  = 1'b1;
    timer_done = done_hit;
    waits = 0;
    @(negedge clk);
    rdy = ws ? bus_ws.pready : bus.pready;
    while (!rdy && waits < 16) begin
      waits++;
      @(negedge clk);
      rdy = ws ? bus_ws.pready : bus.pready;
    end
    rd  = ws ? bus_ws.prdata : bus.prdata;
    err = ws ? bus_ws.pslverr : bus.pslverr;
    @(posedge clk); #1;
    psel_v = 1'b0; penable_v = 1'b0; timer_done = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic ws, input logic [4:0] addr,
                          input logic [31:0] wd, input logic exp_err, input logic done_hit);
    logic [31:0] rd;
    logic        err;
    int          w;
    xfer(ws, 1'b1, addr, wd, done_hit, rd, err, w);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_waits"}, w, ws ? 3 : 0);
  endtask

  task automatic do_read(input string tag, input logic ws, input logic [4:0] addr,
                         input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    int          w;
    xfer(ws, 1'b0, addr, 32'h0, 1'b0, rd, err, w);
    check({tag, "_data"}, rd, exp_data);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_waits"}, w, ws ? 3 : 0);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    timer_done = 1'b1;
    @(posedge clk); #1;
    timer_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; timer_done = 1'b0; done_ws = 1'b0;
    psel_v = 1'b0; penable_v = 1'b0; pwrite_v = 1'b0; sel_ws = 1'b0;
    paddr_v = '0; pwdata_v = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_pready", bus.pready, 0);
    check("rst_pslverr", bus.pslverr, 0);
    check("rst_prdata", bus.prdata, 0);
    check("rst_te", timer_enable, 0);
    check("rst_fv", final_value, 0);
    check("rst_irq", irq, 0);
    for (int i = 0; i < 4; i++) do_read("rst_reg", 1'b0, 5'(i * 4), 32'h0, 1'b0);

    do_write("wr_load", 1'b0, 5'h4, 32'hABCD_E68A, 1'b0, 1'b0);
    check("fv_650", final_value, 10'd650);
    check("te_before_ctrl", timer_enable, 0);
    do_write("wr_ctrl", 1'b0, 5'h0, 32'h3, 1'b0, 1'b0);
    check("te_on", timer_enable, 1);
    do_read("rd_load", 1'b0, 5'h4, 32'h0000_028A, 1'b0);
    do_read("rd_ctrl", 1'b0, 5'h0, 32'h3, 1'b0);

    pulse_done();
    check("irq_lag", irq, 0);
    @(posedge clk); #1;
    check("irq_set", irq, 1);
    pulse_done();
    pulse_done();
    do_read("ticks3", 1'b0, 5'hC, 32'h3, 1'b0);
    do_read("status1", 1'b0, 5'h8, 32'h1, 1'b0);

    do_write("st_w0", 1'b0, 5'h8, 32'h0, 1'b0, 1'b0);
    do_read("st_w0_keep", 1'b0, 5'h8, 32'h1, 1'b0);
    do_write("st_w1c", 1'b0, 5'h8, 32'h1, 1'b0, 1'b0);
    check("irq_still", irq, 1);
    @(posedge clk); #1;
    check("irq_clr", irq, 0);
    do_read("status0", 1'b0, 5'h8, 32'h0, 1'b0);

    do_write("ticks_wr_done", 1'b0, 5'hC, 32'h1234, 1'b0, 1'b1);
    do_read("ticks_is_1", 1'b0, 5'hC, 32'h1, 1'b0);
    do_write("st_w1c_done", 1'b0, 5'h8, 32'h1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 check("irq_set_wins", irq, 1);
    do_read("status_set_wins", 1'b0, 5'h8, 32'h1, 1'b0);

    do_write("ctrl_en_only", 1'b0, 5'h0, 32'h1, 1'b0, 1'b0);
    do_write("load_locked", 1'b0, 5'h4, 32'h5, LOCK, 1'b0);
    check("fv_lock", final_value, LOCK ? 10'd650 : 10'd5);
    check("irq_masked", irq, 0);
    do_read("ctrl_after_lock", 1'b0, 5'h0, 32'h1, 1'b0);
    do_write("ctrl_off", 1'b0, 5'h0, 32'h0, 1'b0, 1'b0);
    do_write("load_free", 1'b0, 5'h4, 32'h5, 1'b0, 1'b0);
    check("fv_5", final_value, 10'd5);
    check("te_off", timer_enable, 0);

    do_write("ticks_clr", 1'b0, 5'hC, 32'h0, 1'b0, 1'b0);
    do_read("ticks_zero", 1'b0, 5'hC, 32'h0, 1'b0);
    @(posedge clk); #1;
    timer_done = 1'b1;
    repeat (65535) @(posedge clk);
    #1 timer_done = 1'b0;
    do_read("ticks_ffff", 1'b0, 5'hC, 32'h0000_FFFF, 1'b0);
    pulse_done();
    do_read("ticks_wrap", 1'b0, 5'hC, 32'h0, 1'b0);

    do_write("ws_ctrl", 1'b1, 5'h0, 32'h1, 1'b0, 1'b0);
    check("ws_pready_one_cycle", bus_ws.pready, 0);
    check("ws_te", te_ws, 1);
    do_write("ws_unmapped_wr", 1'b1, 5'h10, 32'h2, 1'b1, 1'b0);
    do_read("ws_unmapped_rd", 1'b1, 5'h10, 32'h0, 1'b1);
    do_read("ws_ctrl_kept", 1'b1, 5'h0, 32'h1, 1'b0);

    @(posedge clk); #1;
    sel_ws = 1'b1; psel_v = 1'b1; penable_v = 1'b0;
    pwrite_v = 1'b1; paddr_v = 5'h0; pwdata_v = 32'h0;
    @(posedge clk); #1;
    penable_v = 1'b1;
    @(posedge clk); #1;
    psel_v = 1'b0; penable_v = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("ws_abort_te", te_ws, 1);
    do_read("ws_abort_ctrl", 1'b1, 5'h0, 32'h1, 1'b0);

    @(posedge clk); #1;
    sel_ws = 1'b0; psel_v = 1'b1; penable_v = 1'b0;
    pwrite_v = 1'b0; paddr_v = 5'h4; pwdata_v = 32'h0;
    @(posedge clk); #1;
    penable_v = 1'b1;
    reset     = 1'b1;
    @(negedge clk);
    check("rst_mid_pready_before", bus.pready, 1);
    @(posedge clk); #1;
    check("rst_mid_pready", bus.pready, 0);
    check("rst_mid_prdata", bus.prdata, 0);
    check("rst_mid_fv", final_value, 0);
    check("rst_mid_ws_te", te_ws, 0);
    reset = 1'b0; psel_v = 1'b0; penable_v = 1'b0;
    do_read("post_rst_load", 1'b0, 5'h4, 32'h0, 1'b0);
    do_read("post_rst_status", 1'b0, 5'h8, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
